tone_tdm_scheduler: RTL

TONE_TDM_SCHEDULER -- requirements
Module: tone_tdm_scheduler

---
 rtl/tone_tdm_scheduler_pkg.sv | 18 +
 rtl/tone_tdm_scheduler_step.sv | 23 ++
 rtl/tone_tdm_scheduler.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/tone_tdm_scheduler_pkg.sv
// Shared types and default sizing for the time-multiplexed tone generator.
package tone_tdm_scheduler_pkg;

   // Scheduler FSM: idle until a tick, then one channel slot per cycle.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam int DEF_PERIOD_BITS = 12;
   localparam int DEF_CHANNELS    = 3;

   // Slot index width; at least one bit so a single-channel build still has a slot register.
   function automatic int slot_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/tone_tdm_scheduler_step.sv
// One tone step for a single channel: compare against the period, then either
// restart the counter at 1 and flip the square wave, or count up (wrapping).
module tone_step #(
   parameter int PERIOD_BITS = 12
) (
   input  logic [PERIOD_BITS-1:0] i_count,
   input  logic [PERIOD_BITS-1:0] i_period,
   input  logic                   i_out,
   output logic [PERIOD_BITS-1:0] o_count,
   output logic                   o_out
);

   // Periods 0 and 1 both satisfy the compare with a counter that is never below 1.
   always_comb begin
      o_count = i_count + PERIOD_BITS'(1);
      o_out   = i_out;
      if (i_count >= i_period) begin
         o_count = PERIOD_BITS'(1);
         o_out   = ~i_out;
      end
   end

endmodule

// File: rtl/tone_tdm_scheduler.sv
// Tone scheduler: CHANNELS square-wave generators share one tone_step datapath.
// Each tick starts a sweep that visits every channel once, one slot per cycle.
// A tick arriving mid-sweep is queued (one deep); a further tick is dropped and
// flagged in the sticky overrun bit.
module tone_tdm_scheduler
   import tone_tdm_scheduler_pkg::*;
#(
   parameter int PERIOD_BITS = DEF_PERIOD_BITS,
   parameter int CHANNELS    = DEF_CHANNELS
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            tick,
   input  logic [CHANNELS*PERIOD_BITS-1:0] period,
   input  logic                            clear_overrun,
   output logic [CHANNELS-1:0]             out,
   output logic                            busy,
   output logic                            sweep_done,
   output logic                            overrun
);

   localparam int                SLOT_W    = slot_width(CHANNELS);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CHANNELS - 1);

   state_t                  r_state;
   logic [SLOT_W-1:0]       r_slot;
   logic                    r_pending;
   logic [PERIOD_BITS-1:0]  r_count [CHANNELS];
   logic                    r_out   [CHANNELS];
   logic                    r_sweep_done;
   logic                    r_overrun;

   state_t                  w_state_nxt;
   logic [SLOT_W-1:0]       w_slot_nxt;
   logic                    w_pending_nxt;
   logic                    w_proc;
   logic                    w_last;
   logic                    w_drop;
   logic [PERIOD_BITS-1:0]  w_cur_count;
   logic [PERIOD_BITS-1:0]  w_cur_period;
   logic                    w_cur_out;
   logic [PERIOD_BITS-1:0]  w_step_count;
   logic                    w_step_out;

   // Slot mux: pick the current channel's counter, output bit and live period.
   always_comb begin
      w_cur_count  = '0;
      w_cur_period = '0;
      w_cur_out    = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (r_slot == SLOT_W'(i)) begin
            w_cur_count  = r_count[i];
            w_cur_period = period[i*PERIOD_BITS +: PERIOD_BITS];
            w_cur_out    = r_out[i];
         end
      end
   end

   tone_step #(
      .PERIOD_BITS (PERIOD_BITS)
   ) u_step (
      .i_count  (w_cur_count),
      .i_period (w_cur_period),
      .i_out    (w_cur_out),
      .o_count  (w_step_count),
      .o_out    (w_step_out)
   );

   // Next-state logic; at the last slot a queued or fresh tick restarts the sweep
   // directly, and a tick on top of a queued one is dropped.
   always_comb begin
      w_state_nxt   = r_state;
      w_slot_nxt    = r_slot;
      w_pending_nxt = r_pending;
      w_proc        = 1'b0;
      w_last        = 1'b0;
      w_drop        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_slot_nxt = '0;
            if (tick) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_proc = 1'b1;
            if (r_slot == LAST_SLOT) begin
               w_last        = 1'b1;
               w_slot_nxt    = '0;
               w_pending_nxt = 1'b0;
               w_drop        = r_pending & tick;
               if (!(r_pending || tick)) begin
                  w_state_nxt = ST_IDLE;
               end
            end else begin
               w_slot_nxt = r_slot + 1'b1;
               if (tick) begin
                  if (r_pending) begin
                     w_drop = 1'b1;
                  end else begin
                     w_pending_nxt = 1'b1;
                  end
               end
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_slot_nxt    = '0;
            w_pending_nxt = 1'b0;
         end
      endcase
   end

   // Control registers: FSM state, slot index, one-deep tick queue.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_slot    <= '0;
         r_pending <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_slot    <= w_slot_nxt;
         r_pending <= w_pending_nxt;
      end
   end

   // Channel state: write back the stepped counter and output for the active slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_count[i] <= PERIOD_BITS'(1);
            r_out[i]   <= 1'b0;
         end
      end else if (w_proc) begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (r_slot == SLOT_W'(i)) begin
               r_count[i] <= w_step_count;
               r_out[i]   <= w_step_out;
            end
         end
      end
   end

   // Status flags: sweep completion pulse and sticky overrun (set beats clear).
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sweep_done <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_sweep_done <= w_last;
         if (w_drop) begin
            r_overrun <= 1'b1;
         end else if (clear_overrun) begin
            r_overrun <= 1'b0;
         end
      end
   end

   // Flatten the output register array onto the port.
   always_comb begin
      out = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         out[i] = r_out[i];
      end
   end

   assign busy       = (r_state == ST_RUN);
   assign sweep_done = r_sweep_done;
   assign overrun    = r_overrun;

endmodule
